phit_packer_int: RTL and testbench

- Inverse-direction companion to the integer reduction tree. The reduction tree consumes one phit of dwidth_double lanes and produces one scalar; this block takes a stream of dwidth_double scalars and packs them into phit-wide words.
- Sits between scalar-producing compute units (reduction outputs, per-lane results) and the phit-wide network/memory path.
- Valid/ready handshake on both sides.
- Supports partial words via a last flag, with zero padding and a lane-keep mask.

---
 rtl/phit_packer_int_if.sv | 24 ++
 rtl/phit_packer_int.sv | 75 +++++++
 tb/tb_phit_packer_int.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/phit_packer_int_if.sv
// phit_packer_int_if: scalar-in / phit-out valid-ready stream bundle.
interface phit_packer_int_if #(
    parameter int DWIDTH = 64,
    parameter int PHIT   = 512,
    parameter int LANES  = PHIT / DWIDTH
);
    logic [DWIDTH-1:0] s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic [PHIT-1:0]   m_data;
    logic [LANES-1:0]  m_keep;
    logic              m_last;
    logic              m_valid;
    logic              m_ready;
    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_keep, m_last, m_valid
    );
    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_keep, m_last, m_valid
    );
endinterface

// File: rtl/phit_packer_int.sv
// phit_packer_int: packs a stream of DWIDTH scalars into PHIT-wide words with keep mask and last flush.
module phit_packer_int #(
    parameter int DWIDTH = 64,
    parameter int PHIT   = 512,
    parameter int LANES  = PHIT / DWIDTH
) (
    input logic clk,
    input logic rst,
    phit_packer_int_if.slave bus
);
    localparam int CW = $clog2(LANES);
    localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);
    logic [CW-1:0]    cnt;
    logic [PHIT-1:0]  asm_data, asm_next;
    logic [LANES-1:0] asm_keep, keep_next;
    logic             asm_last, pending;
    logic             xfer, complete, slot_free, load;
    logic [PHIT-1:0]  ld_data;
    logic [LANES-1:0] ld_keep;
    logic             ld_last;
    assign bus.s_ready = !pending;
    assign xfer        = bus.s_valid && !pending;
    assign complete    = xfer && (cnt == LAST_LANE || bus.s_last);
    assign slot_free   = !bus.m_valid || bus.m_ready;
    // a held word drains first; a new completion only loads directly when nothing is held
    assign load        = pending ? slot_free : complete && slot_free;
    assign ld_data     = pending ? asm_data : asm_next;
    assign ld_keep     = pending ? asm_keep : keep_next;
    assign ld_last     = pending ? asm_last : bus.s_last;
    always_comb begin
        asm_next  = asm_data;
        keep_next = asm_keep;
        if (xfer) begin
            asm_next[cnt*DWIDTH +: DWIDTH] = bus.s_data;
            keep_next = asm_keep | (LANES'(1) << cnt);
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            asm_data    <= '0;
            asm_keep    <= '0;
            asm_last    <= 1'b0;
            pending     <= 1'b0;
            bus.m_data  <= '0;
            bus.m_keep  <= '0;
            bus.m_last  <= 1'b0;
            bus.m_valid <= 1'b0;
        end else begin
            if (bus.m_valid && bus.m_ready)
                bus.m_valid <= 1'b0;
            if (load) begin
                bus.m_data  <= ld_data;
                bus.m_keep  <= ld_keep;
                bus.m_last  <= ld_last;
                bus.m_valid <= 1'b1;
                asm_data    <= '0;
                asm_keep    <= '0;
                asm_last    <= 1'b0;
                pending     <= 1'b0;
                cnt         <= '0;
            end else if (complete) begin
                asm_data <= asm_next;
                asm_keep <= keep_next;
                asm_last <= bus.s_last;
                pending  <= 1'b1;
                cnt      <= '0;
            end else if (xfer) begin
                asm_data <= asm_next;
                asm_keep <= keep_next;
                cnt      <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_phit_packer_int.sv
// tb_phit_packer_int: directed plus random stimulus against a lane-queue reference model.
module tb_phit_packer_int;
    localparam int DW = 64, PW = 512, LN = 8;
    typedef struct {
        logic [PW-1:0] d;
        logic [LN-1:0] k;
        logic          l;
    } word_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    word_t         exp_q[$];
    logic [DW-1:0] cur[$];
    phit_packer_int_if #(.DWIDTH(DW), .PHIT(PW), .LANES(LN)) bus ();
    phit_packer_int #(.DWIDTH(DW), .PHIT(PW), .LANES(LN)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(string tag, logic [PW-1:0] obs, logic [PW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    // every accepted scalar joins the open message; 8 lanes or last closes a word
    task automatic model_push(logic [DW-1:0] d, logic l);
        word_t w;
        cur.push_back(d);
        if (l || cur.size() == LN) begin
            w.d = '0;
            foreach (cur[i]) w.d[i*DW +: DW] = cur[i];
            w.k = LN'((1 << cur.size()) - 1);
            w.l = l;
            exp_q.push_back(w);
            cur.delete();
        end
    endtask
    task automatic tick();
        chk("m_valid", PW'(bus.m_valid), PW'(exp_q.size() != 0));
        if (bus.m_valid && exp_q.size() != 0) begin
            chk("m_data", bus.m_data, exp_q[0].d);
            chk("m_keep", PW'(bus.m_keep), PW'(exp_q[0].k));
            chk("m_last", PW'(bus.m_last), PW'(exp_q[0].l));
            if (bus.m_ready) void'(exp_q.pop_front());
        end
        if (bus.s_valid && bus.s_ready) model_push(bus.s_data, bus.s_last);
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic send(logic [DW-1:0] d, logic l);
        logic acc = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = bus.s_ready;
            tick();
        end
        if (!acc) chk("send_timeout", PW'(acc), PW'(1));
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask
    initial begin
        logic [PW-1:0] w;
        logic          stalled;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;
        @(negedge clk);
        chk("rst_m_valid", PW'(bus.m_valid), PW'(0));
        chk("rst_m_data", bus.m_data, PW'(0));
        chk("rst_m_keep", PW'(bus.m_keep), PW'(0));
        chk("rst_s_ready", PW'(bus.s_ready), PW'(1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        // full word, continuous
        w = '0;
        for (int i = 0; i < LN; i++) begin
            chk("full_s_ready", PW'(bus.s_ready), PW'(1));
            send(DW'(i + 1), 1'b0);
            w[i*DW +: DW] = DW'(i + 1);
        end
        chk("full_valid", PW'(bus.m_valid), PW'(1));
        chk("full_data", bus.m_data, w);
        chk("full_keep", PW'(bus.m_keep), PW'(8'hFF));
        chk("full_last", PW'(bus.m_last), PW'(0));
        chk("full_s_ready_end", PW'(bus.s_ready), PW'(1));
        // partial flush, then next scalar lands in lane 0
        send(64'hA, 1'b0);
        send(64'hB, 1'b0);
        send(64'hC, 1'b1);
        chk("part_data", bus.m_data, {320'h0, 64'hC, 64'hB, 64'hA});
        chk("part_keep", PW'(bus.m_keep), PW'(8'h07));
        chk("part_last", PW'(bus.m_last), PW'(1));
        send(64'hD, 1'b1);
        chk("part_next_data", bus.m_data, PW'(64'hD));
        chk("part_next_keep", PW'(bus.m_keep), PW'(8'h01));
        // backpressure stall
        tick();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send(DW'(8'h10 + i), 1'b0);
            if (i == 7) begin
                w = '0;
                for (int j = 0; j < LN; j++) w[j*DW +: DW] = DW'(8'h10 + j);
                chk("bp_word1", bus.m_data, w);
            end
        end
        chk("bp_s_ready_low", PW'(bus.s_ready), PW'(0));
        bus.s_valid = 1'b1;
        bus.s_data  = 64'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_s_ready", PW'(bus.s_ready), PW'(0));
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        for (int j = 0; j < LN; j++) w[j*DW +: DW] = DW'(8'h18 + j);
        chk("bp_word2", bus.m_data, w);
        chk("bp_word2_valid", PW'(bus.m_valid), PW'(1));
        chk("bp_s_ready_back", PW'(bus.s_ready), PW'(1));
        tick();
        bus.m_ready = 1'b1;
        tick();
        // single-lane messages back to back
        for (int i = 1; i <= 4; i++) begin
            send(DW'(i), 1'b1);
            chk("single_data", bus.m_data, PW'(i));
            chk("single_keep", PW'(bus.m_keep), PW'(8'h01));
            chk("single_last", PW'(bus.m_last), PW'(1));
        end
        // reset mid-word
        for (int i = 0; i < 5; i++) send(DW'(8'h70 + i), 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("mrst_m_valid", PW'(bus.m_valid), PW'(0));
        chk("mrst_m_data", bus.m_data, PW'(0));
        chk("mrst_m_keep", PW'(bus.m_keep), PW'(0));
        chk("mrst_m_last", PW'(bus.m_last), PW'(0));
        chk("mrst_s_ready", PW'(bus.s_ready), PW'(1));
        exp_q.delete();
        cur.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < LN; i++) send(DW'(8'h80 + i), 1'b0);
        chk("mrst_clean_keep", PW'(bus.m_keep), PW'(8'hFF));
        // extreme values
        for (int i = 0; i < LN; i++)
            send(i[0] ? 64'h8000_0000_0000_0000 : 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        chk("extreme_data", bus.m_data, {4{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF}});
        // random traffic with a source that holds while stalled
        stalled = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!stalled) begin
                bus.s_valid = ($urandom_range(3) != 0);
                bus.s_last  = ($urandom_range(5) == 0);
                bus.s_data  = {$urandom, $urandom};
            end
            bus.m_ready = ($urandom_range(2) != 0);
            stalled = bus.s_valid && !bus.s_ready;
            tick();
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("drain_empty", PW'(exp_q.size()), PW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
